// File: rtl/fanout_backend_nway_if.sv
// Forward/backward token link between the FanOut back-end and its neighbours.
// I_* come from the link side into the back-end, and O_* are driven by the back-end.
interface fanout_backend_nway_if #(
    parameter int WIDTH_DATA = 32
);
    logic                  I_FTk_v;
    logic [WIDTH_DATA-1:0] I_FTk_d;
    logic                  I_FTk_rls;
    logic                  O_FTk_v;
    logic [WIDTH_DATA-1:0] O_FTk_d;
    logic                  I_BTk_n;
    logic                  O_BTk_n;

    modport master (
        output I_FTk_v, I_FTk_d, I_FTk_rls, I_BTk_n,
        input  O_FTk_v, O_FTk_d, O_BTk_n
    );

    modport slave (
        input  I_FTk_v, I_FTk_d, I_FTk_rls, I_BTk_n,
        output O_FTk_v, O_FTk_d, O_BTk_n
    );
endinterface

// File: rtl/fanout_backend_nway.sv
// N-way FanOut link back-end: sequences one block (ID words, then data up to release),
// drives buffer enables and rotates the output path round-robin over enabled paths.
module fanout_backend_nway #(
    parameter int WIDTH_DATA = 32,
    parameter int NUM_PATH   = 4,
    parameter int NUM_ID     = 3,
    parameter int WIDTH_SEL  = $clog2(NUM_PATH)
) (
    input  logic                           clock,
    input  logic                           reset,
    fanout_backend_nway_if.slave           lnk,
    input  logic                           I_Req,
    output logic                           O_Ack,
    input  logic                           I_Unit_Length,
    input  logic                           I_Full_Buff,
    input  logic [NUM_PATH-1:0]            I_Path_En,
    input  logic [NUM_PATH*WIDTH_DATA-1:0] I_PATH,
    output logic [WIDTH_DATA-1:0]          O_PATH,
    output logic [WIDTH_SEL-1:0]           O_Sel,
    output logic                           O_Re_BUFF_ID,
    output logic                           O_We_BUFF,
    output logic                           O_Re_BUFF,
    output logic                           O_is_Busy,
    output logic [15:0]                    O_Blk_Cnt
);
    localparam int WIDTH_CNT = $clog2(NUM_ID + 1);

    typedef enum logic [1:0] {INIT, SEND_ID, RUN} state_t;

    state_t                 state;
    logic [WIDTH_SEL-1:0]   R_Sel;
    logic [WIDTH_CNT-1:0]   R_Cnt;
    logic                   R_Nack;
    logic                   R_Full;
    logic                   R_Unit;
    logic                   R_Rls;

    logic                   fwd;
    logic                   rls_tok;
    logic                   end_send;
    logic [WIDTH_SEL-1:0]   next_sel;
    logic [WIDTH_SEL-1:0]   idx;
    logic                   found;
    logic [WIDTH_DATA-1:0]  path_arr [NUM_PATH];

    for (genvar k = 0; k < NUM_PATH; k++) begin : g_path
        assign path_arr[k] = I_PATH[k*WIDTH_DATA +: WIDTH_DATA];
    end

    assign fwd      = (state != INIT);
    assign rls_tok  = lnk.I_FTk_v & lnk.I_FTk_rls;
    assign end_send = (state == RUN) & ~R_Nack & lnk.I_FTk_v & (lnk.I_FTk_rls | R_Unit);

    assign lnk.O_FTk_v = fwd & lnk.I_FTk_v;
    assign lnk.O_FTk_d = fwd ? lnk.I_FTk_d : '0;
    assign lnk.O_BTk_n = fwd & lnk.I_BTk_n;

    assign O_Ack        = (state == INIT) & I_Req;
    assign O_Re_BUFF_ID = (state == SEND_ID) & ~R_Nack;
    assign O_Re_BUFF    = (state == RUN) & ~R_Nack;
    assign O_We_BUFF    = (I_Req | fwd) & ~(R_Rls | rls_tok) & ~R_Full;
    assign O_is_Busy    = fwd & ~end_send;
    assign O_Sel        = R_Sel;
    assign O_PATH       = path_arr[R_Sel];

    // First enabled path after R_Sel in circular order; hold if none other is enabled.
    always_comb begin
        next_sel = R_Sel;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned k = 1; k < NUM_PATH; k++) begin
            idx = WIDTH_SEL'((32'(R_Sel) + k) % NUM_PATH);
            if (!found && I_Path_En[idx]) begin
                next_sel = idx;
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= INIT;
            R_Sel     <= '0;
            R_Cnt     <= '0;
            R_Nack    <= 1'b0;
            R_Full    <= 1'b0;
            R_Unit    <= 1'b0;
            R_Rls     <= 1'b0;
            O_Blk_Cnt <= '0;
        end else begin
            R_Nack <= lnk.I_BTk_n;
            R_Full <= I_Full_Buff;
            if (state == INIT)
                R_Rls <= 1'b0;
            else if (rls_tok && !I_Req)
                R_Rls <= 1'b1;
            case (state)
                INIT: begin
                    if (I_Req) begin
                        R_Unit <= I_Unit_Length;
                        state  <= SEND_ID;
                    end
                end
                SEND_ID: begin
                    if (lnk.I_FTk_v) begin
                        if (R_Cnt == WIDTH_CNT'(NUM_ID - 1)) begin
                            R_Cnt <= '0;
                            state <= RUN;
                        end else begin
                            R_Cnt <= R_Cnt + WIDTH_CNT'(1);
                        end
                    end
                end
                RUN: begin
                    if (end_send) begin
                        state     <= INIT;
                        O_Blk_Cnt <= O_Blk_Cnt + 16'd1;
                        R_Sel     <= next_sel;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_fanout_backend_nway.sv
// Directed bench for fanout_backend_nway: token forwarding scoreboard plus
// block sequencing, round-robin, nack, full-buffer, unit-length and reset checks.
module tb_fanout_backend_nway;
    localparam int W  = 32;
    localparam int NP = 4;
    localparam int NI = 3;
    localparam int WS = 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fanout_backend_nway_if #(.WIDTH_DATA(W)) lnk();

    logic           I_Req, O_Ack, I_Unit_Length, I_Full_Buff;
    logic [NP-1:0]  I_Path_En;
    logic [NP*W-1:0] I_PATH;
    logic [W-1:0]   O_PATH;
    logic [WS-1:0]  O_Sel;
    logic           O_Re_BUFF_ID, O_We_BUFF, O_Re_BUFF, O_is_Busy;
    logic [15:0]    O_Blk_Cnt;

    fanout_backend_nway #(.WIDTH_DATA(W), .NUM_PATH(NP), .NUM_ID(NI)) dut (
        .clock(clock), .reset(reset), .lnk(lnk),
        .I_Req(I_Req), .O_Ack(O_Ack), .I_Unit_Length(I_Unit_Length),
        .I_Full_Buff(I_Full_Buff), .I_Path_En(I_Path_En), .I_PATH(I_PATH),
        .O_PATH(O_PATH), .O_Sel(O_Sel), .O_Re_BUFF_ID(O_Re_BUFF_ID),
        .O_We_BUFF(O_We_BUFF), .O_Re_BUFF(O_Re_BUFF), .O_is_Busy(O_is_Busy),
        .O_Blk_Cnt(O_Blk_Cnt)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [W+1:0] sb[$];           // {valid, nack, data} expected on the forwarded link
    logic [WS-1:0] exp_sel = '0;
    logic [15:0]   exp_cnt = '0;
    logic [W-1:0]  dword = 32'h1000_0000;
    logic [WS-1:0] rr_seq [4];

    function automatic logic [W-1:0] path_word(input int k);
        return 32'hC0DE_0000 + 32'(k) * 32'h0000_1111;
    endfunction

    function automatic logic [WS-1:0] model_next(input logic [WS-1:0] cur, input logic [NP-1:0] m);
        logic [WS-1:0] c;
        c = cur;
        for (int k = 0; k < NP - 1; k++) begin
            c = c + 1'b1;
            if (m[c]) return c;
        end
        return cur;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive_tok(input logic v, input logic rls, input logic nack);
        logic [W+1:0] e;
        dword = dword + 32'h0000_0101;
        lnk.I_FTk_v = v; lnk.I_FTk_rls = rls; lnk.I_FTk_d = dword; lnk.I_BTk_n = nack;
        sb.push_back({v, nack, dword});
        #1;
        e = sb.pop_front();
        chk("ftk_v", 64'(lnk.O_FTk_v), 64'(e[W+1]));
        chk("btk_n", 64'(lnk.O_BTk_n), 64'(e[W]));
        chk("ftk_d", 64'(lnk.O_FTk_d), 64'(e[W-1:0]));
        chk("path_track", 64'(O_PATH), 64'(path_word(int'(exp_sel))));
    endtask

    task automatic idle_init();
        lnk.I_FTk_v = 1'b1; lnk.I_FTk_rls = 1'b0; lnk.I_FTk_d = 32'hDEAD_BEEF; lnk.I_BTk_n = 1'b1;
        I_Req = 1'b0;
        #1;
        chk("init_ftk_v", 64'(lnk.O_FTk_v), 64'd0);
        chk("init_ftk_d", 64'(lnk.O_FTk_d), 64'd0);
        chk("init_btk_n", 64'(lnk.O_BTk_n), 64'd0);
        chk("init_busy", 64'(O_is_Busy), 64'd0);
        chk("sel", 64'(O_Sel), 64'(exp_sel));
        chk("blk_cnt", 64'(O_Blk_Cnt), 64'(exp_cnt));
        chk("path", 64'(O_PATH), 64'(path_word(int'(exp_sel))));
        tick();
    endtask

    task automatic start_block(input logic unit);
        lnk.I_FTk_v = 1'b0; lnk.I_FTk_rls = 1'b0; lnk.I_BTk_n = 1'b0;
        I_Req = 1'b1; I_Unit_Length = unit;
        #1;
        chk("ack", 64'(O_Ack), 64'd1);
        chk("we_req", 64'(O_We_BUFF), 64'd1);
        chk("busy_req", 64'(O_is_Busy), 64'd0);
        tick();
        I_Req = 1'b0; I_Unit_Length = 1'b0;
    endtask

    task automatic send_ids();
        for (int i = 0; i < NI; i++) begin
            drive_tok(1'b1, 1'b0, 1'b0);
            chk("re_id", 64'(O_Re_BUFF_ID), 64'd1);
            chk("ack_id", 64'(O_Ack), 64'd0);
            chk("re_data_id", 64'(O_Re_BUFF), 64'd0);
            chk("busy_id", 64'(O_is_Busy), 64'd1);
            tick();
            if (i == 0) begin
                drive_tok(1'b0, 1'b0, 1'b0);
                chk("re_id_gap", 64'(O_Re_BUFF_ID), 64'd1);
                tick();
            end
        end
    endtask

    task automatic data_word(input logic we_exp);
        drive_tok(1'b1, 1'b0, 1'b0);
        chk("re_data", 64'(O_Re_BUFF), 64'd1);
        chk("re_id_run", 64'(O_Re_BUFF_ID), 64'd0);
        chk("busy_run", 64'(O_is_Busy), 64'd1);
        chk("we_run", 64'(O_We_BUFF), 64'(we_exp));
        tick();
    endtask

    task automatic block_done();
        exp_cnt = exp_cnt + 16'd1;
        exp_sel = model_next(exp_sel, I_Path_En);
        idle_init();
    endtask

    task automatic end_release();
        drive_tok(1'b1, 1'b1, 1'b0);
        chk("re_rls", 64'(O_Re_BUFF), 64'd1);
        chk("busy_end", 64'(O_is_Busy), 64'd0);
        chk("we_rls", 64'(O_We_BUFF), 64'd0);
        tick();
        block_done();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        lnk.I_FTk_v = 1'b1; lnk.I_FTk_rls = 1'b0; lnk.I_FTk_d = '0; lnk.I_BTk_n = 1'b0;
        I_Req = 1'b0; I_Unit_Length = 1'b0; I_Full_Buff = 1'b0;
        tick();
        #1;
        chk("rst_sel", 64'(O_Sel), 64'd0);
        chk("rst_cnt", 64'(O_Blk_Cnt), 64'd0);
        chk("rst_busy", 64'(O_is_Busy), 64'd0);
        chk("rst_re", 64'(O_Re_BUFF), 64'd0);
        chk("rst_re_id", 64'(O_Re_BUFF_ID), 64'd0);
        chk("rst_we", 64'(O_We_BUFF), 64'd0);
        chk("rst_ftk_v", 64'(lnk.O_FTk_v), 64'd0);
        chk("rst_path", 64'(O_PATH), 64'(path_word(0)));
        reset = 1'b0;
        exp_sel = '0;
        exp_cnt = '0;
        tick();
    endtask

    initial begin
        for (int k = 0; k < NP; k++) I_PATH[k*W +: W] = path_word(k);
        I_Path_En = 4'b1111;
        rr_seq[0] = 2'd1; rr_seq[1] = 2'd3; rr_seq[2] = 2'd1; rr_seq[3] = 2'd3;
        @(negedge clock);
        apply_reset();
        idle_init();

        // Basic block: 3 IDs, 2 data words, release
        start_block(1'b0);
        send_ids();
        data_word(1'b1);
        data_word(1'b1);
        end_release();
        chk("basic_sel", 64'(O_Sel), 64'd1);
        chk("basic_cnt", 64'(O_Blk_Cnt), 64'd1);

        // Round-robin with skip from reset
        apply_reset();
        I_Path_En = 4'b1010;
        for (int b = 0; b < 4; b++) begin
            start_block(1'b0);
            send_ids();
            data_word(1'b1);
            end_release();
            chk("rr_seq", 64'(O_Sel), 64'(rr_seq[b]));
        end

        // Nack in front of the release
        I_Path_En = 4'b1111;
        start_block(1'b0);
        send_ids();
        data_word(1'b1);
        drive_tok(1'b0, 1'b0, 1'b1);
        chk("re_before_nack", 64'(O_Re_BUFF), 64'd1);
        tick();
        drive_tok(1'b1, 1'b1, 1'b0);
        chk("re_nacked", 64'(O_Re_BUFF), 64'd0);
        chk("busy_nacked", 64'(O_is_Busy), 64'd1);
        tick();
        drive_tok(1'b1, 1'b1, 1'b0);
        chk("re_represent", 64'(O_Re_BUFF), 64'd1);
        chk("busy_represent", 64'(O_is_Busy), 64'd0);
        tick();
        block_done();

        // Full buffer for 4 cycles during RUN
        start_block(1'b0);
        send_ids();
        I_Full_Buff = 1'b1;
        data_word(1'b1);
        for (int k = 0; k < 3; k++) data_word(1'b0);
        I_Full_Buff = 1'b0;
        data_word(1'b0);
        data_word(1'b1);
        end_release();

        // Unit-length block ends on its single data word
        start_block(1'b1);
        send_ids();
        drive_tok(1'b1, 1'b0, 1'b0);
        chk("unit_re", 64'(O_Re_BUFF), 64'd1);
        chk("unit_busy", 64'(O_is_Busy), 64'd0);
        tick();
        block_done();
        chk("unit_sel", 64'(O_Sel), 64'd2);

        // Reset in the middle of a block on path 2
        start_block(1'b0);
        send_ids();
        data_word(1'b1);
        apply_reset();
        idle_init();
        start_block(1'b0);
        send_ids();
        end_release();
        chk("post_rst_sel", 64'(O_Sel), 64'd1);
        chk("post_rst_cnt", 64'(O_Blk_Cnt), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fanout_backend_nway.md
Name: fanout_backend_nway

Overview:
Parametrised N-way successor to the two-way FanOut link back-end.
- Sequences one message block at a time: accept request from the FrontEnd, forward NUM_ID ID words, then forward data until a release token ends the block (or after one data word in unit-length mode).
- Drives buffer write/read enables and selects the grant path from NUM_PATH candidates.
- Advances the selection round-robin across enabled paths after each block.
- Sits between the FanOut front-end/buffer and the router output link.

Parameters:
WIDTH_DATA, 32, width of data word and of each path word
NUM_PATH, 4, number of candidate output paths (2..16)
NUM_ID, 3, ID words forwarded per block (1..7)
WIDTH_SEL, $clog2(NUM_PATH), width of path-select index

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
I_FTk_v  in  1  forward token valid
I_FTk_d  in  WIDTH_DATA  forward token data
I_FTk_rls  in  1  forward token carries release (message or flag-message)
O_FTk_v  out  1  forwarded valid
O_FTk_d  out  WIDTH_DATA  forwarded data
I_BTk_n  in  1  downstream nack
O_BTk_n  out  1  nack propagated upstream
I_Req  in  1  block request from FrontEnd
O_Ack  out  1  request accepted
I_Unit_Length  in  1  block is unit-length; sampled with accepted I_Req
I_Full_Buff  in  1  buffer full
I_Path_En  in  NUM_PATH  per-path enable mask
I_PATH  in  NUM_PATH*WIDTH_DATA  packed path words, path k at bits [k*W+:W]
O_PATH  out  WIDTH_DATA  selected path word
O_Sel  out  WIDTH_SEL  current path index
O_Re_BUFF_ID  out  1  read-enable ID buffer
O_We_BUFF  out  1  write-enable data buffer
O_Re_BUFF  out  1  read-enable data buffer
O_is_Busy  out  1  block in progress
O_Blk_Cnt  out  16  completed blocks, wraps at 2^16

Behaviour:
- Reset (synchronous) puts FSM in INIT. R_Sel, R_Nack, R_Full, R_Cnt, R_Unit, R_Rls and O_Blk_Cnt all clear to 0. Every output is 0 at reset, except O_PATH, which equals I_PATH[0].
- Registered state:
  - R_Nack <= I_BTk_n each cycle.
  - R_Full <= I_Full_Buff each cycle.
- FSM states INIT, SEND_ID, RUN:
  - INIT: O_Ack = I_Req, combinational, same cycle. On I_Req: R_Unit <= I_Unit_Length and go to SEND_ID.
  - SEND_ID: O_Re_BUFF_ID = ~R_Nack. R_Cnt increments on each I_FTk_v. When R_Cnt == NUM_ID-1 and I_FTk_v: clear R_Cnt and go to RUN.
  - RUN: O_Re_BUFF = ~R_Nack. End_Send = ~R_Nack & ((I_FTk_v & I_FTk_rls) | (R_Unit & I_FTk_v)). End_Send returns the FSM to INIT.
- Token forwarding: in SEND_ID or RUN, O_FTk_* = I_FTk_* and O_BTk_n = I_BTk_n. In INIT, all are 0.
- Buffer write enable:
  - O_We_BUFF = (I_Req | SEND_ID | RUN) & ~(R_Rls | (I_FTk_v & I_FTk_rls)) & ~R_Full.
  - R_Rls sets on a release token while I_Req = 0, and clears in INIT.
- O_is_Busy = (state != INIT) & ~End_Send.
- Path selection and block count on End_Send:
  - O_Blk_Cnt increments.
  - R_Sel advances to the next index after R_Sel, modulo NUM_PATH, whose I_Path_En bit is 1.
  - If no other bit is set but the current one is, R_Sel holds. If the mask is all 0, R_Sel holds.
  - O_PATH = I_PATH[R_Sel], combinational.
  - R_Sel changes only on End_Send; I_Path_En changes mid-block have no effect until the block ends.
- Nack: a nack on cycle t gates read enables and End_Send on cycle t+1. A release arriving while R_Nack = 1 does not end the block; the FSM stays in RUN until the token is re-presented with R_Nack = 0.
- Simultaneous events: I_Req asserted in the End_Send cycle is ignored. O_Ack can only assert in INIT, so the next block is accepted at the earliest one cycle later.
- Reset mid-block returns to INIT immediately. The selected path goes back to 0 and the block is lost; the bench checks this.
- Unit-length block with NUM_ID = 1 takes exactly 3 cycles: INIT, SEND_ID (one ID), RUN (one data word).

Test Plan:
1. Basic block, NUM_ID=3: I_Req, three valid ID words, two data words, then a release token -> O_Ack pulses for 1 cycle. O_Re_BUFF_ID is high for 3 valid cycles. FSM returns to INIT on the release. O_Sel 0->1, O_Blk_Cnt = 1.
2. Round-robin with skip: I_Path_En = 4'b1010, four blocks -> O_Sel sequence 0 (reset) ->1 ->3 ->1 ->3. O_PATH tracks I_PATH[O_Sel] every cycle.
3. Nack on release: I_BTk_n = 1 in the cycle before the release token -> FSM stays in RUN and O_Re_BUFF = 0 that cycle. Release re-presented with nack low -> block ends. O_BTk_n mirrors I_BTk_n during the block.
4. Full buffer: I_Full_Buff = 1 for 4 cycles during RUN -> O_We_BUFF = 0 from the cycle after assertion until the cycle after deassertion. Forwarding continues unaffected.
5. Unit-length: I_Unit_Length = 1 with I_Req, NUM_ID = 3 ID words then one data word without release -> block ends on that data word. O_is_Busy drops in the same cycle, O_Blk_Cnt increments.
6. Reset mid-block (RUN, O_Sel = 2): reset for 1 cycle -> INIT, O_Sel = 0, O_Blk_Cnt = 0, all enables 0. A subsequent I_Req is accepted normally.
